// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM states, Rcon, and GF(2^8) helpers.
// The S-boxes are computed (field inverse plus affine map) rather than tabulated.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUND,
        FINAL
    } aes_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as required.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless i_skip_mix is set (last round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_skip_mix,
    output logic [127:0] o_state
);

    logic [127:0] w_ark;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Byte (row r, column c) sits at index 4*c+r; row r is rotated right by r.
    always_comb begin
        w_ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(i_state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8])
                    ^ i_rk[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    always_comb begin
        o_state = w_ark;
        if (!i_skip_mix) begin
            for (int c = 0; c < 4; c++) begin
                o_state[127 - 32*c -: 32] = inv_mix_col(w_ark[127 - 32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decryption_block.sv
// Iterative AES-128 decryption core: one-time key expansion into a round-key
// store, then one inverse round per clock with a registered plaintext output.
module aes_decryption_block
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         key_load,
    input  logic [127:0] key,
    input  logic         decrypt_enable,
    input  logic [127:0] input_data,
    output logic [127:0] output_data,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST = 4'(NR);

    aes_state_e   r_state;
    aes_state_e   w_state_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk [0:NR];
    logic [127:0] r_blk;
    logic [127:0] r_out;
    logic         r_key_valid;
    logic         r_done;

    logic         w_key_accept;
    logic         w_dec_accept;
    logic [127:0] w_prev_rk;
    logic [127:0] w_round_rk;
    logic [127:0] w_next_rk;
    logic [127:0] w_round_out;
    logic [31:0]  w_temp;
    logic [31:0]  w_rot;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_key_accept = 1'b0;
        w_dec_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (key_load) begin
                    w_key_accept = 1'b1;
                    w_state_next = EXPAND;
                end else if (decrypt_enable && r_key_valid) begin
                    w_dec_accept = 1'b1;
                    w_state_next = ROUND;
                end
            end
            EXPAND:  if (r_cnt == LAST) w_state_next = IDLE;
            ROUND:   if (r_cnt == 4'd1) w_state_next = FINAL;
            FINAL:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Guarded reads keep an out-of-range counter from indexing past the store.
    always_comb begin
        w_prev_rk  = '0;
        w_round_rk = '0;
        if (r_cnt >= 4'd1 && r_cnt <= LAST) w_prev_rk  = r_rk[r_cnt - 4'd1];
        if (r_cnt <= LAST)                  w_round_rk = r_rk[r_cnt];
    end

    assign w_rot  = {w_prev_rk[23:0], w_prev_rk[31:24]};
    assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {rcon(r_cnt), 24'h0};

    always_comb begin
        w_next_rk[127:96] = w_prev_rk[127:96] ^ w_temp;
        w_next_rk[95:64]  = w_prev_rk[95:64]  ^ w_next_rk[127:96];
        w_next_rk[63:32]  = w_prev_rk[63:32]  ^ w_next_rk[95:64];
        w_next_rk[31:0]   = w_prev_rk[31:0]   ^ w_next_rk[63:32];
    end

    // The counter reaches 0 as ROUND ends, so FINAL picks rk0 from the same mux.
    aes_inv_round u_inv_round (
        .i_state    (r_blk),
        .i_rk       (w_round_rk),
        .i_skip_mix (r_state == FINAL),
        .o_state    (w_round_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt       <= '0;
            r_blk       <= '0;
            r_out       <= '0;
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_key_accept) begin
                        r_rk[0]     <= key;
                        r_key_valid <= 1'b0;
                        r_cnt       <= 4'd1;
                    end else if (w_dec_accept) begin
                        r_blk <= input_data ^ r_rk[NR];
                        r_cnt <= LAST - 4'd1;
                    end
                end
                EXPAND: begin
                    r_rk[r_cnt] <= w_next_rk;
                    if (r_cnt == LAST) begin
                        r_key_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ROUND: begin
                    r_blk <= w_round_out;
                    r_cnt <= r_cnt - 4'd1;
                end
                FINAL: begin
                    r_out  <= w_round_out;
                    r_done <= 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign output_data = r_out;
    assign key_valid   = r_key_valid;
    assign done        = r_done;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_aes_decryption_block.sv
// Directed bench for aes_decryption_block using FIPS-197 vectors; expected
// plaintexts and done cycles go into queues checked by a decoupled monitor.
module tb_aes_decryption_block;

    logic         clk;
    logic         n_rst;
    logic         key_load;
    logic [127:0] key;
    logic         decrypt_enable;
    logic [127:0] input_data;
    logic [127:0] output_data;
    logic         key_valid;
    logic         busy;
    logic         done;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] exp_q[$];
    int           cyc_q[$];

    aes_decryption_block dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .key_load       (key_load),
        .key            (key),
        .decrypt_enable (decrypt_enable),
        .input_data     (input_data),
        .output_data    (output_data),
        .key_valid      (key_valid),
        .busy           (busy),
        .done           (done)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops an expected plaintext and done cycle on every done pulse.
    task automatic monitor();
        logic [127:0] exp_pt;
        int           exp_cyc;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'(done), 128'd0);
                end else begin
                    exp_pt  = exp_q.pop_front();
                    exp_cyc = cyc_q.pop_front();
                    check("plaintext", output_data, exp_pt);
                    check("done_latency", 128'(cyc), 128'(exp_cyc));
                end
            end
        end
    endtask

    // Driver tasks
    task automatic load_key(input logic [127:0] k, input logic [127:0] rk10);
        @(negedge clk);
        key_load = 1'b1;
        key      = k;
        @(negedge clk);
        key_load = 1'b0;
        check("expand_busy", 128'(busy), 128'd1);
        check("key_valid_cleared", 128'(key_valid), 128'd0);
        repeat (9) @(negedge clk);
        check("key_valid_early", 128'(key_valid), 128'd0);
        @(negedge clk);
        check("key_valid_rise", 128'(key_valid), 128'd1);
        check("expand_idle", 128'(busy), 128'd0);
        check("rk10", dut.r_rk[10], rk10);
    endtask

    task automatic drive_dec(input logic [127:0] ct, input logic [127:0] pt, input bit expect_done);
        decrypt_enable = 1'b1;
        input_data     = ct;
        if (expect_done) begin
            exp_q.push_back(pt);
            cyc_q.push_back(cyc + 11);
        end
        @(negedge clk);
        decrypt_enable = 1'b0;
    endtask

    task automatic do_dec(input logic [127:0] ct, input logic [127:0] pt, input bit expect_done);
        @(negedge clk);
        drive_dec(ct, pt, expect_done);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        check("done_seen", 128'(done), 128'd1);
    endtask

    initial begin
        n_rst          = 1'b0;
        key_load       = 1'b0;
        key            = '0;
        decrypt_enable = 1'b0;
        input_data     = '0;
        fork
            monitor();
        join_none
        #1;
        check("rst_output", output_data, 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Decrypt with no key loaded is ignored.
        do_dec(CT1, PT1, 1'b0);
        check("nokey_busy", 128'(busy), 128'd0);
        repeat (12) @(negedge clk);
        check("nokey_output", output_data, 128'd0);

        load_key(KEY1, RK1);
        do_dec(CT1, PT1, 1'b1);
        wait_drain("drain_ct1");

        // Requests while busy are ignored and do not disturb the operation.
        do_dec(CT1, PT1, 1'b1);
        repeat (3) @(negedge clk);
        key_load = 1'b1;
        key      = KEY2;
        drive_dec(CT2, PT2, 1'b0);
        key_load = 1'b0;
        wait_drain("drain_busy_ignore");
        check("busy_keep_key_valid", 128'(key_valid), 128'd1);
        check("busy_keep_rk10", dut.r_rk[10], RK1);

        // Back-to-back: next request issued in the done cycle.
        do_dec(CT1, PT1, 1'b1);
        wait_done();
        drive_dec(CT1, PT1, 1'b1);
        wait_drain("drain_back_to_back");

        // Output holds across a key reload.
        load_key(KEY2, RK2);
        check("hold_across_reload", output_data, PT1);
        do_dec(CT2, PT2, 1'b1);
        wait_drain("drain_ct2");

        // Reset while ROUND counter is 5: in-flight result abandoned.
        do_dec(CT1, PT1, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 128'(busy), 128'd1);
        n_rst = 1'b0;
        #1;
        check("midrst_output", output_data, 128'd0);
        check("midrst_key_valid", 128'(key_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        check("midrst_rk10", dut.r_rk[10], 128'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        do_dec(CT2, PT2, 1'b0);
        check("postrst_nokey_busy", 128'(busy), 128'd0);
        repeat (12) @(negedge clk);

        load_key(KEY1, RK1);
        do_dec(CT1, PT1, 1'b1);
        wait_drain("drain_after_reset");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
